// File: rtl/instr_encoder.sv
// MIPS instruction word builder: encodes symbolic requests and streams
// addressed words to the instruction-memory write port with backpressure.
module instr_encoder #(
    parameter int unsigned              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]        BASE_ADDR = '0,
    parameter int unsigned              DEPTH     = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        op_sel_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [15:0]       imm_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [15:0]       count_o,
    output logic              err_o,
    output logic              done_o
);

    localparam int unsigned     CNT_W   = 16;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       word;
    logic              legal;
    logic              accept;
    logic              acc_legal;
    logic              acc_illegal;
    logic              handshake;

    // Encoder: unused fields are forced to zero so they never leak into the word.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op_sel_i)
            4'd0:    word = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h21};
            4'd1:    word = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h23};
            4'd2:    word = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h24};
            4'd3:    word = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h25};
            4'd4:    word = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h2A};
            4'd5:    word = {6'h00, 5'd0, rt_i, rd_i, shamt_i, 6'h03};
            4'd6:    word = {6'h00, rs_i, rt_i, rd_i, 5'd0, 6'h07};
            4'd7:    word = {6'h08, rs_i, rt_i, imm_i};
            4'd8:    word = {6'h0B, rs_i, rt_i, imm_i};
            4'd9:    word = {6'h0F, 5'd0, rt_i, imm_i};
            4'd10:   word = {6'h0D, rs_i, rt_i, imm_i};
            4'd11:   word = {6'h04, rs_i, rt_i, imm_i};
            4'd12:   word = {6'h05, rs_i, rt_i, imm_i};
            default: legal = 1'b0;
        endcase
    end

    // Request side is open only in RUN, with room in the output slot and in the run budget.
    always_comb begin
        req_ready_o = (state == S_RUN) && (!instr_valid_o || instr_ready_i) &&
                      (count_o < DEPTH_C);
        accept      = req_valid_i && req_ready_o;
        acc_legal   = accept && legal;
        acc_illegal = accept && !legal;
        handshake   = instr_valid_o && instr_ready_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= S_IDLE;
            wr_addr       <= BASE_ADDR;
            instr_o       <= '0;
            addr_o        <= BASE_ADDR;
            instr_valid_o <= 1'b0;
            count_o       <= '0;
            err_o         <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            // A same-cycle legal accept refills the slot, keeping one word per cycle.
            if (acc_legal) begin
                instr_o       <= word;
                addr_o        <= wr_addr;
                instr_valid_o <= 1'b1;
                wr_addr       <= wr_addr + ADDR_STEP;
                count_o       <= count_o + CNT_ONE;
            end else if (handshake) begin
                instr_valid_o <= 1'b0;
            end

            if (acc_illegal) begin
                err_o <= 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state   <= S_RUN;
                        wr_addr <= BASE_ADDR;
                        count_o <= '0;
                        err_o   <= 1'b0;
                        done_o  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (acc_legal && (count_o + CNT_ONE == DEPTH_C)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!instr_valid_o || handshake) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded MIPS words, stalls,
// illegal ops, run-length limit and reset during a stall.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  op_sel_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [15:0] imm_i;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [15:0] count_o;
    logic        err_o;
    logic        done_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] hs_word[$];
    logic [31:0] hs_addr[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .op_sel_i      (op_sel_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .rd_i          (rd_i),
        .shamt_i       (shamt_i),
        .imm_i         (imm_i),
        .instr_o       (instr_o),
        .addr_o        (addr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o),
        .err_o         (err_o),
        .done_o        (done_o)
    );

    // Record every completed output handshake
    always @(posedge clk) begin
        if (rst_i && instr_valid_o && instr_ready_i) begin
            hs_word.push_back(instr_o);
            hs_addr.push_back(addr_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] hs_w(input int i);
        return (i < hs_word.size()) ? hs_word[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] hs_a(input int i);
        return (i < hs_addr.size()) ? hs_addr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic [3:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [4:0] sh, input logic [15:0] imm);
        req_valid_i = v;
        op_sel_i    = op;
        rs_i        = rs;
        rt_i        = rt;
        rd_i        = rd;
        shamt_i     = sh;
        imm_i       = imm;
    endtask

    task automatic do_reset();
        rst_i   = 1'b0;
        start_i = 1'b0;
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        hs_word.delete();
        hs_addr.delete();
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ops [6];
        logic       rdy [6];
        ops = '{4'd15, 4'd1, 4'd2, 4'd4, 4'd6, 4'd10};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        instr_ready_i = 1'b1;
        rst_i         = 1'b0;
        start_i       = 1'b0;
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        tick();
        #1;
        check("rst_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_count", count_o, 0);
        check("rst_err", err_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ready", req_ready_o, 0);

        // Single addu
        do_reset();
        do_start();
        set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        #1;
        check("t1_req_ready", req_ready_o, 1);
        tick();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        check("t1_valid", instr_valid_o, 1);
        check("t1_instr", instr_o, 32'h00221821);
        check("t1_addr", addr_o, 32'h0);
        check("t1_count", count_o, 1);
        tick();
        check("t1_valid_drop", instr_valid_o, 0);
        check("t1_hs_n", hs_word.size(), 1);

        // Back-to-back addi, lui, bne
        do_reset();
        do_start();
        set_req(1'b1, 4'd7, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF);
        tick();
        check("t2_w0", instr_o, 32'h2008FFFF);
        check("t2_a0", addr_o, 32'h0);
        set_req(1'b1, 4'd9, 5'd7, 5'd9, 5'd0, 5'd0, 16'h1234);
        tick();
        check("t2_w1", instr_o, 32'h3C091234);
        check("t2_a1", addr_o, 32'h4);
        set_req(1'b1, 4'd12, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFD);
        tick();
        check("t2_w2", instr_o, 32'h1509FFFD);
        check("t2_a2", addr_o, 32'h8);
        check("t2_count", count_o, 3);
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        tick();
        check("t2_hs_n", hs_word.size(), 3);
        check("t2_hs_w2", hs_w(2), 32'h1509FFFD);

        // sra with a stalled output
        do_reset();
        do_start();
        instr_ready_i = 1'b0;
        set_req(1'b1, 4'd5, 5'd31, 5'd5, 5'd4, 5'd3, 16'h0);
        tick();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        check("t3_instr", instr_o, 32'h000520C3);
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_ready", req_ready_o, 0);
            check("t3_stall_valid", instr_valid_o, 1);
            check("t3_stall_instr", instr_o, 32'h000520C3);
            tick();
        end
        check("t3_hs_none", hs_word.size(), 0);
        instr_ready_i = 1'b1;
        #1;
        check("t3_ready_rise", req_ready_o, 1);
        tick();
        check("t3_valid_drop", instr_valid_o, 0);
        check("t3_hs_n", hs_word.size(), 1);
        check("t3_hs_w", hs_w(0), 32'h000520C3);

        // Illegal op between two legal ones
        do_reset();
        do_start();
        set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        tick();
        set_req(1'b1, 4'd14, 5'd9, 5'd9, 5'd9, 5'd9, 16'h5555);
        tick();
        check("t4_err_set", err_o, 1);
        check("t4_no_word", instr_valid_o, 0);
        check("t4_count1", count_o, 1);
        set_req(1'b1, 4'd3, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0);
        tick();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        check("t4_or_instr", instr_o, 32'h00853025);
        check("t4_or_addr", addr_o, 32'h4);
        check("t4_count2", count_o, 2);
        tick();
        check("t4_err_sticky", err_o, 1);
        check("t4_hs_n", hs_word.size(), 2);
        check("t4_hs_a0", hs_a(0), 32'h0);
        check("t4_hs_a1", hs_a(1), 32'h4);

        // Run-length limit of 4 words, then restart
        do_reset();
        do_start();
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, ops[i], 5'd1, 5'd2, 5'd3, 5'd5, 16'h00AA);
            #1;
            check($sformatf("t5_req_ready%0d", i), req_ready_o, rdy[i]);
            tick();
        end
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        check("t5_done", done_o, 1);
        check("t5_count", count_o, 4);
        check("t5_err", err_o, 1);
        check("t5_ready_done", req_ready_o, 0);
        check("t5_hs_n", hs_word.size(), 4);
        check("t5_w0", hs_w(0), 32'h00221823);
        check("t5_w1", hs_w(1), 32'h00221824);
        check("t5_w2", hs_w(2), 32'h0022182A);
        check("t5_w3", hs_w(3), 32'h00221807);
        check("t5_a3", hs_a(3), 32'hC);
        do_start();
        check("t5_rs_count", count_o, 0);
        check("t5_rs_err", err_o, 0);
        check("t5_rs_done", done_o, 0);
        set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        tick();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        check("t5_rs_addr", addr_o, 32'h0);
        check("t5_rs_instr", instr_o, 32'h00221821);

        // Reset while a word is stalled
        do_reset();
        do_start();
        instr_ready_i = 1'b0;
        set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        tick();
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        check("t6_valid_pre", instr_valid_o, 1);
        rst_i = 1'b0;
        #1;
        check("t6_valid_rst", instr_valid_o, 0);
        check("t6_count_rst", count_o, 0);
        instr_ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        tick();
        check("t6_hs_none", hs_word.size(), 0);
        check("t6_valid_post", instr_valid_o, 0);
        check("t6_idle_ready", req_ready_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
